// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between the 6502 core and the
// program loader. It grants one requester per cycle, returns read data to its
// owner one cycle later, blocks CPU writes into the ROM window, and gives the
// loader exclusive ownership while ldr_lock is held.
module mem_arbiter #(
  parameter int unsigned        ADDR_W       = 16,
  parameter int unsigned        DATA_W       = 8,
  parameter logic [ADDR_W-1:0]  ROM_BASE     = 'hC000,
  parameter int unsigned        STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Loader port
  input  logic              ldr_lock,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  // Memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              locked,
  output logic              wp_err
);

  localparam int unsigned       CNT_W   = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0]  LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic {NORMAL, LOCK} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               cpu_rd_q, cpu_rd_d;
  logic               ldr_rd_q, ldr_rd_d;
  logic [DATA_W-1:0]  cpu_hold_q, ldr_hold_q;
  logic               wp_err_q, wp_err_d;
  logic               wp_hit;

  assign wp_hit = cpu_we && (cpu_addr >= ROM_BASE);

  // State register, starvation counter, read ownership, held read data, sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      cpu_rd_q   <= 1'b0;
      ldr_rd_q   <= 1'b0;
      cpu_hold_q <= '0;
      ldr_hold_q <= '0;
      wp_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      cpu_rd_q   <= cpu_rd_d;
      ldr_rd_q   <= ldr_rd_d;
      cpu_hold_q <= cpu_rdata;
      ldr_hold_q <= ldr_rdata;
      wp_err_q   <= wp_err_d;
    end
  end

  // Next state, arbitration, memory steering and bookkeeping
  always_comb begin
    state_d   = ldr_lock ? LOCK : NORMAL;
    cpu_gnt   = 1'b0;
    ldr_gnt   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    starve_d  = starve_q;
    wp_err_d  = wp_err_q;

    // Grants are combinational; holding them low during reset keeps the
    // memory port quiet until reset is released.
    if (rst_n) begin
      if (state_q == LOCK) begin
        ldr_gnt = ldr_req;
      end else if ((starve_q >= LIMIT) && ldr_req) begin
        ldr_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (ldr_req) begin
        ldr_gnt = 1'b1;
      end
    end

    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we && !wp_hit;
      if (wp_hit) wp_err_d = 1'b1;
    end else if (ldr_gnt) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      mem_we    = ldr_we;
    end

    if ((state_q == LOCK) || !ldr_req || ldr_gnt) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    cpu_rd_d = cpu_gnt && !cpu_we;
    ldr_rd_d = ldr_gnt && !ldr_we;
  end

  // Read return: the owner sees memory data directly in the response cycle,
  // otherwise its last value is held. rvalid is masked during reset so a
  // read pending across reset assertion is dropped.
  always_comb begin
    cpu_rvalid = cpu_rd_q && rst_n;
    ldr_rvalid = ldr_rd_q && rst_n;
    cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold_q;
    ldr_rdata  = ldr_rvalid ? mem_rdata : ldr_hold_q;
  end

  assign locked = (state_q == LOCK);
  assign wp_err = wp_err_q;

endmodule
